// File: rtl/if_id_stage.sv
// Fetch stage: program counter, IF/ID pipeline register and instruction field decode.
// Optional performance counters are enabled with `define IF_ID_PERF_CNT_EN.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMM_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             id_valid,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_instr,
  output logic [5:0]       id_op,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_shamt,
  output logic [5:0]       id_funct,
  output logic [IMM_W-1:0] id_imm,
  output logic             id_sign_ext,
  output logic [25:0]      id_target,
  output logic [31:0]      fetch_count,
  output logic [31:0]      bubble_count
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        load_if_id;

  assign pc_plus4   = pc_q + 32'd4;
  assign load_if_id = !flush && !stall;

  // Redirect wins over stall for the PC; flush wins over stall for IF/ID.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect)   pc_d = {redirect_pc[31:2], 2'b00};
    else if (stall) pc_d = pc_q;
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = 32'd0;
      pc4_d   = 32'd0;
    end else if (!stall) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = valid_q;
  assign id_instr  = instr_q;
  assign id_pc4    = pc4_q;
  assign id_op     = instr_q[31:26];
  assign id_rs     = instr_q[25:21];
  assign id_rt     = instr_q[20:16];
  assign id_rd     = instr_q[15:11];
  assign id_shamt  = instr_q[10:6];
  assign id_funct  = instr_q[5:0];
  assign id_imm    = instr_q[IMM_W-1:0];
  assign id_target = instr_q[25:0];

  // Branches, arithmetic immediates and memory offsets are signed; logical immediates are not.
  always_comb begin
    id_sign_ext = 1'b0;
    case (instr_q[31:26])
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: id_sign_ext = valid_q;
      default: id_sign_ext = 1'b0;
    endcase
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + {31'd0, load_if_id};
    bubble_count_d = bubble_count_q + {31'd0, flush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  assign fetch_count  = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Random + directed bench for if_id_stage against a behavioural fetch model.
module tb_if_id_stage;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          IMM_W = 16;

  logic             clk = 1'b0;
  logic             rst, stall, flush, redirect;
  logic [31:0]      redirect_pc, imem_addr, imem_rdata;
  logic             id_valid, id_sign_ext;
  logic [31:0]      id_pc4, id_instr, fetch_count, bubble_count;
  logic [5:0]       id_op, id_funct;
  logic [4:0]       id_rs, id_rt, id_rd, id_shamt;
  logic [IMM_W-1:0] id_imm;
  logic [25:0]      id_target;

  if_id_stage #(.RESET_PC(RPC), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_instr(id_instr), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_imm(id_imm), .id_sign_ext(id_sign_ext),
    .id_target(id_target), .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: a hash of the address, optionally overridden by a fixed word.
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'd0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  assign imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Behavioural model
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
  logic        m_valid;
  bit          chk_en = 0;

  always @(posedge clk) begin
    logic [31:0] fetched;
    fetched = ovr_en ? ovr_val : mem_word(m_pc);
    if (rst) begin
      m_pc = RPC; m_valid = 0; m_instr = 0; m_pc4 = 0; m_fc = 0; m_bc = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_instr = 0; m_pc4 = 0; m_bc = m_bc + 1;
      end else if (!stall) begin
        m_valid = 1; m_instr = fetched; m_pc4 = m_pc + 4; m_fc = m_fc + 1;
      end
      if (redirect)    m_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (!stall) m_pc = m_pc + 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] op;
      logic       se;
      op = 6'(m_instr >> 26);
      se = m_valid && (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B});
      chk("imem_addr", imem_addr, m_pc);
      chk("id_valid",  32'(id_valid), 32'(m_valid));
      chk("id_instr",  id_instr, m_instr);
      chk("id_pc4",    id_pc4, m_pc4);
      chk("id_op",     32'(id_op), 32'(op));
      chk("id_rs",     32'(id_rs), (m_instr >> 21) % 32);
      chk("id_rt",     32'(id_rt), (m_instr >> 16) % 32);
      chk("id_rd",     32'(id_rd), (m_instr >> 11) % 32);
      chk("id_shamt",  32'(id_shamt), (m_instr >> 6) % 32);
      chk("id_funct",  32'(id_funct), m_instr % 64);
      chk("id_imm",    32'(id_imm), m_instr % (32'd1 << IMM_W));
      chk("id_target", 32'(id_target), m_instr % (32'd1 << 26));
      chk("id_sign_ext", 32'(id_sign_ext), 32'(se));
`ifdef IF_ID_PERF_CNT_EN
      chk("fetch_count",  fetch_count, m_fc);
      chk("bubble_count", bubble_count, m_bc);
`else
      chk("fetch_count",  fetch_count, 32'd0);
      chk("bubble_count", bubble_count, 32'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_bc;
    rst = 1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    @(negedge clk);
    step();
    chk_en = 1;
    chk("reset imem_addr", imem_addr, 32'h0040_0000);
    chk("reset id_valid", 32'(id_valid), 32'd0);
    rst = 0;
    step();
    chk("first instr", id_instr, mem_word(32'h0040_0000));
    chk("first pc4", id_pc4, 32'h0040_0004);
    chk("first valid", 32'(id_valid), 32'd1);

    ovr_en = 1; ovr_val = 32'h2128_FFFF;
    step();
    chk("addi op", 32'(id_op), 32'h08);
    chk("addi rs", 32'(id_rs), 32'd9);
    chk("addi rt", 32'(id_rt), 32'd8);
    chk("addi imm", 32'(id_imm), 32'h0000_FFFF);
    chk("addi sext", 32'(id_sign_ext), 32'd1);
    ovr_val = 32'h3528_FFFF;
    step();
    chk("ori sext", 32'(id_sign_ext), 32'd0);
    ovr_en = 0;

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall addr", imem_addr, 32'h0040_000C);
      chk("stall instr", id_instr, 32'h3528_FFFF);
    end

    flush = 1;
    step();
    chk("flush valid", 32'(id_valid), 32'd0);
    chk("flush instr", id_instr, 32'd0);
    chk("flush pc held", imem_addr, 32'h0040_000C);
`ifdef IF_ID_PERF_CNT_EN
    exp_bc = 32'd1;
`else
    exp_bc = 32'd0;
`endif
    chk("flush bubble_count", bubble_count, exp_bc);
    flush = 0;

    redirect = 1; redirect_pc = 32'h0040_0103;
    step();
    chk("redirect addr", imem_addr, 32'h0040_0100);
    redirect = 0; stall = 0;
    step();
    chk("redirect pc4", id_pc4, 32'h0040_0104);

    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap addr0", imem_addr, 32'hFFFF_FFFC);
    redirect = 0;
    step();
    chk("wrap addr1", imem_addr, 32'h0000_0000);
    chk("wrap pc4", id_pc4, 32'h0000_0000);

    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(99) < 2);
      stall    = ($urandom_range(99) < 25);
      flush    = ($urandom_range(99) < 10);
      redirect = ($urandom_range(99) < 10);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : $urandom;
      ovr_en  = ($urandom_range(7) == 0);
      ovr_val = {6'($urandom_range(63)), 26'($urandom)};
      step();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
